// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimation filter.
// The integrator/decimator half and the downstream comb chain both use
// CIC_OW so that the two halves agree on the wrapped arithmetic width.
package cic_pkg;

    // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Default filter configuration.
    localparam int CIC_W  = 10;
    localparam int CIC_N  = 3;
    localparam int CIC_R  = 8;

    // Bit growth of n integrators at ratio r is n*clog2(r); this width is
    // exactly enough for wrapped integrators to give exact comb results.
    localparam int CIC_OW = CIC_W + CIC_N * clog2(CIC_R);

endpackage

// File: rtl/integrator_stage.sv
// One integrator of the CIC chain: a modular accumulator plus the flop that
// carries the sample qualifier to the next stage, so every stage sees its
// input exactly one cycle after the previous stage updated.
module integrator_stage
    import cic_pkg::*;
#(
    parameter int ow = CIC_OW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          en,
    input  logic [ow-1:0] din,
    output logic [ow-1:0] dout,
    output logic          vld_out
);

    logic [ow-1:0] r_acc;
    logic          r_vld;

    // Accumulate on qualified samples and delay the qualifier by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
            r_vld <= 1'b0;
        end else if (clr) begin
            r_acc <= '0;
            r_vld <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the next stage read this
            // accumulator's pre-edge value, which is what keeps the pipeline
            // skew correct; blocking here would collapse stages together.
            r_vld <= en;
            if (en) begin
                // Plain ow-bit addition: wrap-around is intended, the comb
                // differences downstream cancel it exactly.
                r_acc <= r_acc + din;
            end
        end
    end

    assign dout    = r_acc;
    assign vld_out = r_vld;

endmodule

// File: rtl/cic_integrator_decim.sv
// Integrator and decimator half of a CIC decimation filter.
// n cascaded integrators run at the input rate; every r-th result leaving
// the last stage is registered as one output sample with a one-cycle strobe.
// A synchronous clr empties the pipeline and the decimation phase but keeps
// the last output sample on dout.
module cic_integrator_decim
    import cic_pkg::*;
#(
    parameter int w  = CIC_W,
    parameter int n  = CIC_N,
    parameter int r  = CIC_R,
    parameter int ow = CIC_OW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [w-1:0]  din,
    input  logic          din_vld,
    input  logic          clr,
    output logic [ow-1:0] dout,
    output logic          dout_vld
);

    // Decimation counter width; at least one bit since r >= 2.
    localparam int CW = (clog2(r) < 1) ? 1 : clog2(r);
    localparam logic [CW-1:0] CNT_LAST = CW'(r - 1);

    // Reject configurations the wrapped arithmetic cannot support.
    if (n < 1 || n > 6) begin : g_bad_n
        $error("cic_integrator_decim: n must be in 1..6");
    end
    if (r < 2) begin : g_bad_r
        $error("cic_integrator_decim: r must be at least 2");
    end
    if (ow < w + n * clog2(r)) begin : g_bad_ow
        $error("cic_integrator_decim: ow must be >= w + n*clog2(r)");
    end

    // Stage k reads index k-1; index 0 is the sign-extended input sample.
    logic [ow-1:0] w_acc [0:n];
    logic          w_vld [0:n];

    assign w_acc[0] = {{(ow - w){din[w-1]}}, din};
    assign w_vld[0] = din_vld;

    for (genvar k = 1; k <= n; k++) begin : g_stage
        integrator_stage #(
            .ow (ow)
        ) u_stage (
            .clk     (clk),
            .rstn    (rstn),
            .clr     (clr),
            .en      (w_vld[k-1]),
            .din     (w_acc[k-1]),
            .dout    (w_acc[k]),
            .vld_out (w_vld[k])
        );
    end

    logic [CW-1:0] r_cnt;
    logic [ow-1:0] r_dout;
    logic          r_dout_vld;

    // Count qualified last-stage results and capture every r-th one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else if (clr) begin
            // dout deliberately keeps its last sample across a clear.
            r_cnt      <= '0;
            r_dout_vld <= 1'b0;
        end else if (w_vld[n]) begin
            if (r_cnt == CNT_LAST) begin
                r_dout     <= w_acc[n];
                r_dout_vld <= 1'b1;
                r_cnt      <= '0;
            end else begin
                r_cnt      <= r_cnt + CW'(1);
                r_dout_vld <= 1'b0;
            end
        end else begin
            r_dout_vld <= 1'b0;
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;

endmodule

// File: tb/tb_cic_integrator_decim.sv
// Self-checking bench for cic_integrator_decim (w=10, n=3, r=8, ow=19).
// The reference model keeps every valid sample since the last reset/clear and
// computes the n-fold running sum directly from binomial weights, modulo 2^ow.
// A single process drives inputs after each rising edge and checks outputs on
// the following falling edge.
module tb_cic_integrator_decim;

    localparam int W  = 10;
    localparam int N  = 3;
    localparam int R  = 8;
    localparam int OW = 19;

    logic          clk;
    logic          rstn;
    logic [W-1:0]  din;
    logic          din_vld;
    logic          clr;
    logic [OW-1:0] dout;
    logic          dout_vld;

    cic_integrator_decim #(
        .w  (W),
        .n  (N),
        .r  (R),
        .ow (OW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .din      (din),
        .din_vld  (din_vld),
        .clr      (clr),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [OW-1:0] val;
    } exp_t;

    exp_t          exp_q[$];
    int            hist[$];
    int            mcnt;
    int            cyc;
    logic [OW-1:0] model_dout;
    int            n_cmp;
    int            n_mis;
    int            n_strobes;
    logic [OW-1:0] last_strobe;
    logic [OW-1:0] comb_d [N];
    logic [OW-1:0] comb_out;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic longint binom(input int a, input int b);
        longint res;
        res = 1;
        for (int i = 1; i <= b; i++) res = res * longint'(a - b + i) / longint'(i);
        return res;
    endfunction

    // n-fold running sum of all samples since the last reset/clear:
    // sample j of m contributes x_j * C(m-1-j + n-1, n-1).
    function automatic logic [OW-1:0] model_output();
        longint      acc;
        logic [63:0] bits;
        int          m;
        acc = 0;
        m   = hist.size();
        for (int j = 0; j < m; j++) acc += longint'(hist[j]) * binom(m - 1 - j + N - 1, N - 1);
        bits = acc;
        return bits[OW-1:0];
    endfunction

    task automatic model_clear();
        exp_q.delete();
        hist.delete();
        mcnt = 0;
    endtask

    // Compare outputs produced by the edge numbered cyc.
    task automatic monitor();
        logic [OW-1:0] cv;
        logic [OW-1:0] tmp;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_vld", 64'(dout_vld), 64'd1);
            check("strobe_val", 64'(dout), 64'(e.val));
            model_dout = e.val;
        end else begin
            check("idle_vld", 64'(dout_vld), 64'd0);
            check("hold_dout", 64'(dout), 64'(model_dout));
        end
        if (dout_vld) begin
            n_strobes   = n_strobes + 1;
            last_strobe = dout;
            cv = dout;
            for (int k = 0; k < N; k++) begin
                tmp       = cv;
                cv        = cv - comb_d[k];
                comb_d[k] = tmp;
            end
            comb_out = cv;
        end
    endtask

    // Drive one cycle of inputs (sampled at edge cyc+1) and check the result.
    task automatic apply(input logic v, input logic [W-1:0] x, input logic c);
        exp_t e;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        din     = x;
        din_vld = v;
        clr     = c;
        if (rstn) begin
            if (c) begin
                // Strobes due at or after the clearing edge never appear.
                while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due >= cyc + 1)
                    void'(exp_q.pop_back());
                hist.delete();
                mcnt = 0;
            end else if (v) begin
                hist.push_back(int'(signed'(x)));
                mcnt = mcnt + 1;
                if (mcnt == R) begin
                    e.due = cyc + 1 + N;
                    e.val = model_output();
                    exp_q.push_back(e);
                    mcnt = 0;
                end
            end
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int k);
        repeat (k) apply(1'b0, '0, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        rstn    = 1'b1;
        din_vld = 1'b0;
        clr     = 1'b0;
        @(negedge clk);
        monitor();
    endtask

    // Reset asserted between edges while streaming: outputs clear at once.
    task automatic async_reset();
        @(posedge clk);
        cyc = cyc + 1;
        #3;
        rstn = 1'b0;
        model_clear();
        model_dout = '0;
        #1;
        check("arst_dout", 64'(dout), 64'd0);
        check("arst_vld", 64'(dout_vld), 64'd0);
        @(negedge clk);
        monitor();
    endtask

    // One impulse followed by 15 zeros: strobes of 36 then 136.
    task automatic impulse_test(input string tag);
        int base;
        base = n_strobes;
        apply(1'b1, W'(1), 1'b0);
        repeat (7) apply(1'b1, '0, 1'b0);
        idle(N + 2);
        check({tag, "_cnt1"}, 64'(n_strobes - base), 64'd1);
        check({tag, "_val1"}, 64'(last_strobe), 64'd36);
        repeat (8) apply(1'b1, '0, 1'b0);
        idle(N + 2);
        check({tag, "_cnt2"}, 64'(n_strobes - base), 64'd2);
        check({tag, "_val2"}, 64'(last_strobe), 64'd136);
    endtask

    initial begin
        int base;
        n_cmp       = 0;
        n_mis       = 0;
        n_strobes   = 0;
        cyc         = 0;
        mcnt        = 0;
        model_dout  = '0;
        last_strobe = '0;
        comb_out    = '0;
        for (int k = 0; k < N; k++) comb_d[k] = '0;
        rstn    = 1'b0;
        din     = '0;
        din_vld = 1'b0;
        clr     = 1'b0;

        // Reset held while din_vld toggles: outputs stay at zero.
        for (int i = 0; i < 6; i++) apply(1'(i % 2), W'(i + 3), 1'b0);
        release_reset();

        // Eight zero samples give exactly one zero-valued strobe.
        base = n_strobes;
        repeat (8) apply(1'b1, '0, 1'b0);
        idle(N + 2);
        check("reset_zero_cnt", 64'(n_strobes - base), 64'd1);
        check("reset_zero_val", 64'(last_strobe), 64'd0);

        // Impulse response.
        impulse_test("impulse");

        // Unit step at 50% valid duty: single strobe of 120.
        apply(1'b0, '0, 1'b1);
        base = n_strobes;
        for (int i = 0; i < 16; i++) apply(1'((i % 2) == 0), W'(1), 1'b0);
        idle(N + 2);
        check("step_cnt", 64'(n_strobes - base), 64'd1);
        check("step_val", 64'(last_strobe), 64'd120);

        // Full-scale DC through a bench comb chain settles to 511*r^n.
        apply(1'b0, '0, 1'b1);
        for (int k = 0; k < N; k++) comb_d[k] = '0;
        repeat (80) apply(1'b1, W'(511), 1'b0);
        idle(N + 2);
        check("dc_comb", 64'(comb_out), 64'd261632);

        // Clear mid-frame, with a valid sample in the clearing cycle.
        apply(1'b0, '0, 1'b1);
        repeat (5) apply(1'b1, W'($urandom), 1'b0);
        apply(1'b1, W'($urandom), 1'b1);
        base = n_strobes;
        repeat (7) apply(1'b1, W'($urandom), 1'b0);
        idle(N + 2);
        check("clr_early_cnt", 64'(n_strobes - base), 64'd0);
        apply(1'b1, W'($urandom), 1'b0);
        idle(N + 2);
        check("clr_cnt", 64'(n_strobes - base), 64'd1);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 600; i++)
            apply(1'($urandom_range(0, 9) < 7), W'($urandom), 1'($urandom_range(0, 49) == 0));

        // Asynchronous reset during streaming, then impulse again.
        repeat (40) apply(1'b1, W'($urandom), 1'b0);
        async_reset();
        apply(1'b1, W'($urandom), 1'b0);
        apply(1'b1, W'($urandom), 1'b0);
        release_reset();
        impulse_test("post_arst");

        idle(N + 4);
        check("pending", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/cic_integrator_decim.md
Name: cic_integrator_decim

Overview:
- Integrator and decimator half of a CIC decimation filter; the differentiator (comb) stages run downstream at the decimated rate.
- Holds n cascaded modular accumulators at the input sample rate, qualified by a sample-valid strobe.
- A decimation counter forwards every r-th last-stage result as one output sample with a one-cycle valid strobe.

Parameters:
- w, 10: input sample width, signed two's complement.
- n, 3: number of integrator stages, 1..6.
- r, 8: decimation ratio, at least 2.
- ow, 19: accumulator and output width; must satisfy ow >= w + n*clog2(r). Elaboration error otherwise.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- din  in  w  signed input sample.
- din_vld  in  1  input sample qualifier; gaps allowed, back-to-back allowed.
- clr  in  1  synchronous clear of the filter state.
- dout  out  ow  signed decimated integrator output.
- dout_vld  out  1  one-cycle strobe, high while dout holds a new sample.

Behaviour:
- Clock and reset: single clock clk; rstn is asynchronous and active-low.
- Reset state: all acc[k]=0, all s_vld[k]=0, cnt=0, dout=0, dout_vld=0.
- Stage 1 (on a clk edge with din_vld=1): acc[1] <= acc[1] + sext(din); s_vld[1] <= din_vld every cycle.
- Stage k>1 (on an edge with s_vld[k-1]=1): acc[k] <= acc[k] + acc[k-1]; s_vld[k] <= s_vld[k-1] every cycle.
- Stage hold: a stage whose qualifier is low keeps its value.
- Arithmetic: all sums are ow-bit and wrap modulo 2^ow. No saturation; wrap is required for correct CIC operation.
- Decimation counter cnt, range 0..r-1, advances only on edges with s_vld[n]=1.
  - If cnt==r-1: dout <= acc[n], dout_vld <= 1, cnt <= 0.
  - Otherwise: cnt <= cnt+1, dout_vld <= 0.
- Output hold: dout holds between strobes; dout_vld is never high for two consecutive cycles unless r-th samples arrive that way.
- Latency: if the r-th valid sample is sampled at edge T, dout_vld is high in the cycle after edge T+n.
- First output: the first strobe after reset/clr reflects exactly r input samples.
- clr=1 at an edge:
  - acc[*], s_vld[*] and cnt go to 0, and dout_vld goes to 0.
  - dout keeps its last value.
  - clr overrides din_vld sampled in the same cycle; that sample is discarded.
  - Samples in flight in the pipeline are discarded.
- Reset mid-operation: immediate return to the reset state, including dout=0; in-flight samples are lost.
- No backpressure: dout_vld is a strobe, and the downstream comb must accept it in that cycle.

Decomposition:
- Shared package cic_pkg holds:
  - the clog2 function;
  - default constants CIC_W=10, CIC_N=3, CIC_R=8;
  - derived CIC_OW = CIC_W + CIC_N*clog2(CIC_R), also used by the downstream comb chain.
- One sub-module, integrator_stage (params ow; ports clk, rstn, clr, en, din[ow], dout[ow], vld_out):
  - one accumulator plus its qualifier flop;
  - instantiated n times with a generate loop.
- Counter and output register stay in the top level.

Test Plan:
- Reset: hold rstn=0 while din_vld toggles → dout=0, dout_vld=0; release, feed 8 samples of 0 → one strobe with dout=0.
- Impulse (n=3, r=8): din=1 for one valid sample, then 15 valid zeros → strobes with dout=36, then 136; first strobe in the cycle after edge T+3.
- Step with gaps: din=1 constant, din_vld at 50% duty, 8 valid samples → single strobe with dout=120; no strobe before the 8th valid sample.
- Full-scale DC: din=511 continuous, then a bench model of 3 comb stages on the decimated output → settles to 261632; raw dout wraps without error.
- clr mid-frame: 5 valid samples, then clr with din_vld=1 in the same cycle → cnt restarts, and the next strobe follows exactly 8 further valid samples, with the value computed from those samples only.
- Async reset mid-operation: assert rstn low between clock edges during streaming → outputs go to 0 immediately; the post-release impulse test reproduces 36.
